// File: rtl/clock_rate_ctrl.sv
// clock_rate_ctrl: fractional clock-enable generator (accumulator divider)
// whose (div, mul) rate is shared between NREQ requesters. A round-robin
// arbiter accepts one config at a time into shadow registers; the shadow is
// applied at the next divider terminal event so `enable` never sees a short
// or partial phase.
//
// Optional build macro: CLKCTRL_IMMEDIATE_EN
//   defined   -> captured config is applied on the first cycle after grant
//                (acc cleared, no toggle, no tick).
//   undefined -> config applied on the next terminal event (default).
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   req_valid  per-requester config request, held until accepted
//   req_div    packed div values, requester k at [k*W +: W]
//   req_mul    packed mul values, same packing
//   req_ready  one-hot single-cycle accept pulse
//   enable     toggling enable to the clock gating stage
//   tick       one-cycle pulse in every cycle where enable toggles
//   busy       a config is captured but not yet applied
//   cur_owner  index of the requester whose config is active
module clock_rate_ctrl #(
    parameter int unsigned W       = 32,
    parameter int unsigned NREQ    = 2,
    parameter int unsigned DEF_DIV = 3,
    parameter int unsigned DEF_MUL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_div,
    input  logic [NREQ*W-1:0] req_mul,
    output logic [NREQ-1:0]   req_ready,
    output logic              enable,
    output logic              tick,
    output logic              busy,
    output logic [2:0]        cur_owner
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t          state, state_n;
    logic [W-1:0]    acc, acc_n;
    logic [W-1:0]    div_r, div_n;
    logic [W-1:0]    mul_r, mul_n;
    logic [W-1:0]    shadow_div, shadow_div_n;
    logic [W-1:0]    shadow_mul, shadow_mul_n;
    logic [2:0]      shadow_owner, shadow_owner_n;
    logic [PW-1:0]   rr_ptr, rr_ptr_n;
    logic [NREQ-1:0] req_ready_n;
    logic            enable_n, tick_n, busy_n;
    logic [2:0]      cur_owner_n;

    logic            term_c;
    logic [W:0]      sum_c;
    logic            apply_c;
    logic            gnt_found_c;
    logic [PW-1:0]   gnt_idx_c;
    logic [W-1:0]    gnt_div_c, gnt_mul_c;
    int unsigned     idx_c;

    // Round-robin search: lowest valid index at or after rr_ptr, wrapping.
    always_comb begin
        gnt_found_c = 1'b0;
        gnt_idx_c   = '0;
        gnt_div_c   = '0;
        gnt_mul_c   = '0;
        idx_c       = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx_c = 32'(rr_ptr) + i;
            if (idx_c >= NREQ) begin
                idx_c = idx_c - NREQ;
            end
            if (!gnt_found_c && req_valid[PW'(idx_c)]) begin
                gnt_found_c = 1'b1;
                gnt_idx_c   = PW'(idx_c);
                gnt_div_c   = W'(req_div >> (idx_c * W));
                gnt_mul_c   = W'(req_mul >> (idx_c * W));
            end
        end
    end

    // Next-state: divider step, arbitration and config apply.
    always_comb begin
        state_n        = state;
        acc_n          = acc;
        div_n          = div_r;
        mul_n          = mul_r;
        shadow_div_n   = shadow_div;
        shadow_mul_n   = shadow_mul;
        shadow_owner_n = shadow_owner;
        rr_ptr_n       = rr_ptr;
        req_ready_n    = '0;
        enable_n       = enable;
        tick_n         = 1'b0;
        busy_n         = busy;
        cur_owner_n    = cur_owner;
        apply_c        = 1'b0;

        term_c = (acc >= div_r);
        sum_c  = {1'b0, acc} + {1'b0, mul_r};

        // Saturate instead of wrapping so a large mul can never skip the terminal.
        if (term_c) begin
            acc_n    = '0;
            enable_n = ~enable;
            tick_n   = 1'b1;
        end else if (sum_c[W]) begin
            acc_n = '1;
        end else begin
            acc_n = sum_c[W-1:0];
        end

        case (state)
            IDLE: begin
                if (gnt_found_c) begin
                    req_ready_n    = NREQ'(1) << gnt_idx_c;
                    shadow_div_n   = gnt_div_c;
                    shadow_mul_n   = gnt_mul_c;
                    shadow_owner_n = 3'(gnt_idx_c);
                    rr_ptr_n       = (gnt_idx_c == PW'(NREQ - 1)) ? '0 : gnt_idx_c + PW'(1);
                    busy_n         = 1'b1;
                    state_n        = PENDING;
                end
            end
            PENDING: begin
`ifdef CLKCTRL_IMMEDIATE_EN
                apply_c  = 1'b1;
                acc_n    = '0;
                enable_n = enable;
                tick_n   = 1'b0;
`else
                // A frozen divider (mul=0) never reaches a terminal, so apply directly.
                if (term_c) begin
                    apply_c = 1'b1;
                end else if (mul_r == '0) begin
                    apply_c = 1'b1;
                    acc_n   = '0;
                end
`endif
            end
        endcase

        if (apply_c) begin
            div_n       = shadow_div;
            mul_n       = shadow_mul;
            cur_owner_n = shadow_owner;
            busy_n      = 1'b0;
            state_n     = IDLE;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            div_r        <= W'(DEF_DIV);
            mul_r        <= W'(DEF_MUL);
            shadow_div   <= '0;
            shadow_mul   <= '0;
            shadow_owner <= '0;
            rr_ptr       <= '0;
            req_ready    <= '0;
            enable       <= 1'b0;
            tick         <= 1'b0;
            busy         <= 1'b0;
            cur_owner    <= '0;
        end else begin
            state        <= state_n;
            acc          <= acc_n;
            div_r        <= div_n;
            mul_r        <= mul_n;
            shadow_div   <= shadow_div_n;
            shadow_mul   <= shadow_mul_n;
            shadow_owner <= shadow_owner_n;
            rr_ptr       <= rr_ptr_n;
            req_ready    <= req_ready_n;
            enable       <= enable_n;
            tick         <= tick_n;
            busy         <= busy_n;
            cur_owner    <= cur_owner_n;
        end
    end

endmodule

// File: tb/tb_clock_rate_ctrl.sv
// Testbench for clock_rate_ctrl: directed scenarios plus randomized traffic,
// every cycle checked against a behavioural model of the rate controller.
module tb_clock_rate_ctrl;
    localparam int unsigned W    = 8;
    localparam int unsigned NREQ = 3;
    localparam int          MAXV = (1 << W) - 1;
    localparam int          DDIV = 3;
    localparam int          DMUL = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   valid;
    logic [W-1:0]      rdiv [NREQ];
    logic [W-1:0]      rmul [NREQ];
    logic [NREQ*W-1:0] req_div_p, req_mul_p;
    logic [NREQ-1:0]   req_ready;
    logic              enable, tick, busy;
    logic [2:0]        cur_owner;
    logic [NREQ+5:0]   obs, ref_v;

    int n_cmp = 0;
    int n_err = 0;

    // Model state
    int              m_acc, m_div, m_mul, m_rr, m_sdiv, m_smul, m_sown, m_owner;
    bit              m_en, m_tick, m_busy, m_pend;
    logic [NREQ-1:0] m_ready;

    clock_rate_ctrl #(.W(W), .NREQ(NREQ), .DEF_DIV(DDIV), .DEF_MUL(DMUL)) dut (
        .clk(clk), .rst(rst), .req_valid(valid), .req_div(req_div_p), .req_mul(req_mul_p),
        .req_ready(req_ready), .enable(enable), .tick(tick), .busy(busy), .cur_owner(cur_owner)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_div_p = '0;
        req_mul_p = '0;
        for (int k = 0; k < NREQ; k++) begin
            req_div_p[k*W +: W] = rdiv[k];
            req_mul_p[k*W +: W] = rmul[k];
        end
    end

    assign obs = {req_ready, enable, tick, busy, cur_owner};

    // Behavioural model: one clock edge of the rate controller.
    task automatic model_step(input logic r);
        int              n_acc;
        bit              n_en, n_tick, term, apply;
        logic [NREQ-1:0] n_ready;
        if (r) begin
            m_acc = 0; m_div = DDIV; m_mul = DMUL; m_en = 0; m_tick = 0;
            m_ready = '0; m_busy = 0; m_owner = 0; m_pend = 0; m_rr = 0;
            m_sdiv = 0; m_smul = 0; m_sown = 0;
        end else begin
            term    = (m_acc >= m_div);
            n_ready = '0;
            apply   = 0;
            if (term) begin
                n_acc = 0; n_en = !m_en; n_tick = 1;
            end else begin
                n_acc = m_acc + m_mul;
                if (n_acc > MAXV) n_acc = MAXV;
                n_en = m_en; n_tick = 0;
            end
            if (!m_pend) begin
                for (int i = 0; i < NREQ; i++) begin
                    int g;
                    g = (m_rr + i) % NREQ;
                    if (valid[g] && n_ready == '0) begin
                        n_ready[g] = 1'b1;
                        m_sdiv = int'(rdiv[g]);
                        m_smul = int'(rmul[g]);
                        m_sown = g;
                        m_rr   = (g + 1) % NREQ;
                        m_pend = 1;
                        m_busy = 1;
                    end
                end
            end else begin
`ifdef CLKCTRL_IMMEDIATE_EN
                apply = 1; n_acc = 0; n_en = m_en; n_tick = 0;
`else
                if (term) apply = 1;
                else if (m_mul == 0) begin apply = 1; n_acc = 0; end
`endif
                if (apply) begin
                    m_div = m_sdiv; m_mul = m_smul; m_owner = m_sown;
                    m_busy = 0; m_pend = 0;
                end
            end
            m_acc = n_acc; m_en = n_en; m_tick = n_tick; m_ready = n_ready;
        end
        ref_v = {m_ready, m_en, m_tick, m_busy, 3'(m_owner)};
    endtask

    // One clock: advance model, then requesters drop valid after a transfer.
    task automatic cycle();
        logic [NREQ-1:0] prev_ready;
        prev_ready = m_ready;
        @(posedge clk);
        model_step(rst);
        #1;
        valid = valid & ~prev_ready;
    endtask

    task automatic submit(input int k, input int d, input int m);
        rdiv[k]  = W'(d);
        rmul[k]  = W'(m);
        valid[k] = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid = '0;
        cycle();
        cycle();
        n_cmp++;
        if (obs !== ref_v) begin
            n_err++; $display("FAIL reset_model got=%h exp=%h", obs, ref_v);
        end
        n_cmp++;
        if ({req_ready, enable, tick, busy, cur_owner} !== '0) begin
            n_err++; $display("FAIL reset_zero got=%h exp=0", obs);
        end
        rst = 1'b0;
    endtask

    task automatic test_default();
        int nt = 0;
        for (int c = 0; c < 16; c++) begin
            cycle();
            n_cmp++;
            if (obs !== ref_v) begin
                n_err++; $display("FAIL default c=%0d got=%h exp=%h", c, obs, ref_v);
            end
            if (tick === 1'b1) nt++;
        end
        n_cmp++;
        if (nt != 4) begin
            n_err++; $display("FAIL default_ticks got=%0d exp=4", nt);
        end
    endtask

    task automatic test_req0();
        int t0 = -1, gap = -1, c;
        for (c = 0; c < 10 && m_acc != 1; c++) begin
            cycle();
            n_cmp++;
            if (obs !== ref_v) begin
                n_err++; $display("FAIL req0_pre got=%h exp=%h", obs, ref_v);
            end
        end
        submit(0, 1, 1);
        cycle();
        n_cmp++;
        if (req_ready !== NREQ'(1)) begin
            n_err++; $display("FAIL req0_ready got=%b exp=%b", req_ready, NREQ'(1));
        end
        for (c = 0; c < 50 && !(busy === 1'b0 && valid == '0); c++) begin
            cycle();
            n_cmp++;
            if (obs !== ref_v) begin
                n_err++; $display("FAIL req0_wait c=%0d got=%h exp=%h", c, obs, ref_v);
            end
        end
        for (c = 0; c < 20; c++) begin
            cycle();
            n_cmp++;
            if (obs !== ref_v) begin
                n_err++; $display("FAIL req0_run c=%0d got=%h exp=%h", c, obs, ref_v);
            end
            if (tick === 1'b1) begin
                if (t0 >= 0 && gap < 0) gap = c - t0;
                t0 = c;
            end
        end
        n_cmp++;
        if (gap != 2 || cur_owner !== 3'd0) begin
            n_err++; $display("FAIL req0_rate gap=%0d owner=%0d exp gap=2 owner=0", gap, cur_owner);
        end
    endtask

    task automatic test_round_robin();
        int t0 = -1, gap = -1, c;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        submit(0, 1, 1);
        submit(1, 7, 2);
        for (c = 0; c < 200 && !(busy === 1'b0 && valid == '0); c++) begin
            cycle();
            n_cmp++;
            if (obs !== ref_v) begin
                n_err++; $display("FAIL rr_wait c=%0d got=%h exp=%h", c, obs, ref_v);
            end
        end
        for (c = 0; c < 30; c++) begin
            cycle();
            n_cmp++;
            if (obs !== ref_v) begin
                n_err++; $display("FAIL rr_run c=%0d got=%h exp=%h", c, obs, ref_v);
            end
            if (tick === 1'b1) begin
                if (t0 >= 0 && gap < 0) gap = c - t0;
                t0 = c;
            end
        end
        n_cmp++;
        if (gap != 5 || cur_owner !== 3'd1) begin
            n_err++; $display("FAIL rr_rate gap=%0d owner=%0d exp gap=5 owner=1", gap, cur_owner);
        end
    endtask

    task automatic test_saturate();
        int t0 = -1, gap = -1, c;
        submit(2, 255, 200);
        for (c = 0; c < 600 && !(busy === 1'b0 && valid == '0); c++) begin
            cycle();
            n_cmp++;
            if (obs !== ref_v) begin
                n_err++; $display("FAIL sat_wait c=%0d got=%h exp=%h", c, obs, ref_v);
            end
        end
        for (c = 0; c < 20; c++) begin
            cycle();
            n_cmp++;
            if (obs !== ref_v) begin
                n_err++; $display("FAIL sat_run c=%0d got=%h exp=%h", c, obs, ref_v);
            end
            if (tick === 1'b1) begin
                if (t0 >= 0 && gap < 0) gap = c - t0;
                t0 = c;
            end
        end
        n_cmp++;
        if (gap != 3 || cur_owner !== 3'd2) begin
            n_err++; $display("FAIL sat_rate gap=%0d owner=%0d exp gap=3 owner=2", gap, cur_owner);
        end
    endtask

    task automatic test_frozen();
        int nt = 0, nb = 0, c;
        submit(0, 5, 0);
        for (c = 0; c < 600 && !(busy === 1'b0 && valid == '0); c++) begin
            cycle();
            n_cmp++;
            if (obs !== ref_v) begin
                n_err++; $display("FAIL frz_wait c=%0d got=%h exp=%h", c, obs, ref_v);
            end
        end
        for (c = 0; c < 12; c++) begin
            cycle();
            n_cmp++;
            if (obs !== ref_v) begin
                n_err++; $display("FAIL frz_hold c=%0d got=%h exp=%h", c, obs, ref_v);
            end
            if (tick === 1'b1) nt++;
        end
        n_cmp++;
        if (nt != 0) begin
            n_err++; $display("FAIL frz_ticks got=%0d exp=0", nt);
        end
        submit(1, 0, 1);
        for (c = 0; c < 6; c++) begin
            cycle();
            n_cmp++;
            if (obs !== ref_v) begin
                n_err++; $display("FAIL frz_apply c=%0d got=%h exp=%h", c, obs, ref_v);
            end
            if (busy === 1'b1) nb++;
        end
        n_cmp++;
        if (nb != 1) begin
            n_err++; $display("FAIL frz_busy_len got=%0d exp=1", nb);
        end
        nt = 0;
        for (c = 0; c < 10; c++) begin
            cycle();
            n_cmp++;
            if (obs !== ref_v) begin
                n_err++; $display("FAIL fast c=%0d got=%h exp=%h", c, obs, ref_v);
            end
            if (tick === 1'b1) nt++;
        end
        n_cmp++;
        if (nt != 10) begin
            n_err++; $display("FAIL fast_ticks got=%0d exp=10", nt);
        end
    endtask

    task automatic test_reset_pending();
        int nt = 0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        submit(0, 200, 1);
        cycle();
        cycle();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL rstp_busy got=%b exp=1", busy);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_cmp++;
        if ({req_ready, enable, tick, busy, cur_owner} !== '0) begin
            n_err++; $display("FAIL rstp_clear got=%h exp=0", obs);
        end
        for (int c = 0; c < 16; c++) begin
            cycle();
            n_cmp++;
            if (obs !== ref_v) begin
                n_err++; $display("FAIL rstp_run c=%0d got=%h exp=%h", c, obs, ref_v);
            end
            if (tick === 1'b1) nt++;
        end
        n_cmp++;
        if (nt != 4 || cur_owner !== 3'd0) begin
            n_err++; $display("FAIL rstp_rate ticks=%0d owner=%0d exp ticks=4 owner=0", nt, cur_owner);
        end
    endtask

    task automatic test_random();
        int d, m;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < NREQ; k++) begin
                if (!valid[k] && !m_ready[k] && $urandom_range(0, 19) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       d = int'($urandom_range(0, 3));
                        1:       d = int'($urandom_range(0, 15));
                        2:       d = int'($urandom_range(240, 255));
                        default: d = int'($urandom_range(0, 255));
                    endcase
                    m = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 255));
                    submit(k, d, m);
                end
            end
            cycle();
            n_cmp++;
            if (obs !== ref_v) begin
                n_err++; $display("FAIL random c=%0d got=%h exp=%h", c, obs, ref_v);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        valid = '0;
        for (int k = 0; k < NREQ; k++) begin
            rdiv[k] = '0;
            rmul[k] = '0;
        end
        m_ready = '0;
        ref_v = '0;
        test_reset();
        test_default();
        test_req0();
        test_round_robin();
        test_saturate();
        test_frozen();
        test_reset_pending();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/clock_rate_ctrl.md
Name: clock_rate_ctrl

Overview:
- Owns one fractional clock-enable generator (accumulator divider) and shares its rate configuration between NREQ requesters.
- Requesters submit new (div, mul) pairs over valid/ready. A round-robin arbiter picks one at a time.
- The accepted config is applied only at the next divider terminal event, so the `enable` toggle never sees a partial or short phase.
- Sits between the control/CPU side and the custom_clock gating stage, which consumes `enable`.

Parameters:
- W, 32, width of div, mul and the accumulator.
- NREQ, 2, number of config requesters (1..8).
- DEF_DIV, 3, div loaded at reset.
- DEF_MUL, 1, mul loaded at reset.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester config request; must be held until accepted.
- req_div  input  NREQ*W  packed div values; requester k occupies bits [k*W +: W].
- req_mul  input  NREQ*W  packed mul values; same packing as req_div.
- req_ready  output  NREQ  one-hot one-cycle accept pulse; transfer happens when valid & ready.
- enable  output  1  toggling enable to custom_clock.
- tick  output  1  one-cycle pulse in every cycle where `enable` toggles.
- busy  output  1  high while a config is captured but not yet applied.
- cur_owner  output  3  index of the requester whose config is currently active; 0 after reset.

Behaviour:
- Reset (rst=1 at posedge) sets:
  - acc=0, div_r=DEF_DIV, mul_r=DEF_MUL;
  - enable=0, tick=0, req_ready=0, busy=0, cur_owner=0;
  - state=IDLE, rr_ptr=0, shadow regs=0.
- Reset mid-PENDING discards the shadow config; the requester must resubmit.
- Divider, every cycle:
  - acc < div_r: acc <= acc+mul_r, computed in W+1 bits. If the carry is set, acc saturates to all-ones.
  - Otherwise (terminal event): enable <= ~enable, tick <= 1 for that cycle, acc <= 0.
  - div_r=0: terminal every cycle, so enable toggles every cycle.
  - mul_r=0 and div_r>0: acc frozen, enable holds, no ticks.
- FSM states IDLE, PENDING:
  - IDLE, with any req_valid: grant the lowest index >= rr_ptr with valid set, wrapping around.
    - Assert req_ready[g] for exactly one cycle.
    - Capture req_div/req_mul[g] into shadow regs and g into shadow_owner.
    - Go to PENDING, busy <= 1, rr_ptr <= (g+1) mod NREQ.
  - PENDING, no terminal event: wait. Ignore all requests; req_ready stays 0.
  - PENDING, terminal event: normal toggle and acc <= 0 occur, plus div_r/mul_r <= shadow, cur_owner <= shadow_owner, busy <= 0, go to IDLE. The new rate governs counting from the next cycle.
  - PENDING while mul_r=0 (divider frozen): apply the shadow on the next cycle with acc <= 0 and no toggle, then go to IDLE.
- Throughput and latency:
  - Grant latency: 1 cycle from valid, when IDLE.
  - An IDLE cycle is required between two grants, so at most one grant per two cycles.
- Simultaneous events:
  - A request arriving in the same cycle as an apply is not granted until the FSM is back in IDLE, i.e. the following cycle.
  - A grant coinciding with a terminal event captures only. Apply waits for the next terminal event.
- Requesters dropping valid before ready is a protocol violation; the outcome is undefined and there is no check.

Optional Feature:
- Macro: CLKCTRL_IMMEDIATE_EN.
- Defined: PENDING applies on the first cycle after the grant regardless of acc.
  - div_r/mul_r <= shadow, acc <= 0, enable unchanged, no tick.
  - busy is high for exactly 1 cycle.
- Undefined: boundary-aligned apply as described in Behaviour.

Test Plan:
- Reset, then defaults div=3, mul=1, no requests: acc sequence 0,1,2,3; tick every 4th cycle; enable period 8 cycles; busy=0.
- Req0 div=1, mul=1 while acc=1 under default config: req_ready[0] pulses 1 cycle after valid; busy stays high until the acc=3 terminal event. After that, tick every 2 cycles and cur_owner=0.
- Both req_valid high, rr_ptr=0: req0 granted first. After its apply, req1 (div=7, mul=2) is granted next; ticks then every 5 cycles (acc 0,2,4,6,8→terminal); cur_owner=1.
- W=8, div=255, mul=200: 0→200→255 (saturated)→terminal. Expect a tick every 3 cycles and no wraparound.
- Apply mul=0, div=5: enable frozen, no ticks. A new request div=0, mul=1 applies 1 cycle after its grant, without waiting for a terminal event; enable then toggles every cycle.
- rst asserted while busy=1: busy=0, enable=0, div_r=DEF_DIV, mul_r=DEF_MUL, cur_owner=0; the pending config is never applied.
- With CLKCTRL_IMMEDIATE_EN: grant at acc=1 → next cycle acc=0, new rate active, no tick in that cycle.
